// File: rtl/uart_rx_frame_sequencer_pkg.sv
// Shared types and constants for the length-prefixed UART frame receiver.
package uart_rx_frame_sequencer_pkg;

    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned LEN_W     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StGap,
        StCheck,
        StWrite,
        StDone,
        StErr
    } state_e;

    typedef enum logic [0:0] {
        PhHeader,
        PhPayload
    } phase_e;

    function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                       input int unsigned      max_words);
        return (len != '0) && (32'(len) <= max_words);
    endfunction

endpackage

// File: rtl/uart_rx_frame_sequencer_if.sv
// Control, byte-handshake and buffer-write signals of the frame sequencer.
interface uart_rx_frame_sequencer_if
    import uart_rx_frame_sequencer_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 10
) ();

    logic                    start;
    logic                    abort;
    logic [ADDR_W-1:0]       base_addr;
    logic                    read_enable;
    logic                    byte_recieved;
    logic [7:0]              uart_byte;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*WORD_BYTES-1:0] wr_data;
    logic                    busy;
    logic                    frame_done;
    logic                    frame_err;
    logic [LEN_W-1:0]        word_count;

    modport slave (
        input  start, abort, base_addr, byte_recieved, uart_byte,
        output read_enable, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, word_count
    );

    modport master (
        output start, abort, base_addr, byte_recieved, uart_byte,
        input  read_enable, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, word_count
    );

endinterface

// File: rtl/uart_rx_frame_sequencer_packer.sv
// Packs incoming bytes MSB-first into a word; o_full marks a completed word.
module uart_rx_frame_sequencer_packer #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [7:0]              i_byte,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_full
);

    localparam int unsigned WordW = 8 * WORD_BYTES;
    localparam int unsigned CntW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WORD_BYTES - 1);

    logic [WordW-1:0] r_shift;
    logic [CntW-1:0]  r_cnt;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_shift <= (r_shift << 8) | WordW'(i_byte);
            // full stays set until the first byte of the next word arrives
            if (r_cnt == LastIdx) begin
                r_cnt  <= '0;
                r_full <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_full <= 1'b0;
            end
        end
    end

    assign o_word = r_shift;
    assign o_full = r_full;

endmodule

// File: rtl/uart_rx_frame_sequencer.sv
// Requests bytes from the UART interface, parses a 2-byte big-endian word count and
// writes the packed payload words to a buffer starting at base_addr.
module uart_rx_frame_sequencer
    import uart_rx_frame_sequencer_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input logic                      clk,
    input logic                      rst,
    uart_rx_frame_sequencer_if.slave bus
);

    localparam logic [1:0] HdrCntFull = 2'(HDR_BYTES);

    state_e                  r_state;
    state_e                  w_state_next;
    phase_e                  r_phase;
    phase_e                  w_phase_next;
    logic [1:0]              r_hdr_cnt;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_word_count;
    logic [LEN_W-1:0]        r_word_idx;
    logic [ADDR_W-1:0]       r_base;
    logic                    r_busy;
    logic                    r_byte_prev;

    logic                    w_byte_edge;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_hdr_load;
    logic                    w_len_ok;
    logic                    w_last_word;
    logic                    w_full;
    logic [8*WORD_BYTES-1:0] w_word;

    uart_rx_frame_sequencer_packer #(
        .WORD_BYTES(WORD_BYTES)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_accept),
        .i_load (w_load),
        .i_byte (bus.uart_byte),
        .o_word (w_word),
        .o_full (w_full)
    );

    assign w_byte_edge = bus.byte_recieved & ~r_byte_prev;
    assign w_len_ok    = len_legal(r_len, MAX_WORDS);
    assign w_last_word = (r_word_idx + LEN_W'(1)) == r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_hdr_load   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_phase_next = PhHeader;
                    w_state_next = StReq;
                end
            end
            StReq: w_state_next = StWait;
            StWait: begin
                if (w_byte_edge) begin
                    w_state_next = StGap;
                    if (r_phase == PhPayload) begin
                        w_load = 1'b1;
                    end else begin
                        w_hdr_load = 1'b1;
                    end
                end
            end
            StGap: begin
                // the next request waits until the interface drops byte_recieved
                if (!bus.byte_recieved) begin
                    if (r_phase == PhHeader) begin
                        w_state_next = (r_hdr_cnt == HdrCntFull) ? StCheck : StReq;
                    end else begin
                        w_state_next = w_full ? StWrite : StReq;
                    end
                end
            end
            StCheck: begin
                if (w_len_ok) begin
                    w_phase_next = PhPayload;
                    w_state_next = StReq;
                end else begin
                    w_state_next = StErr;
                end
            end
            StWrite: w_state_next = w_last_word ? StDone : StReq;
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        if (bus.abort && !(r_state inside {StIdle, StDone, StErr})) begin
            w_state_next = StErr;
            w_phase_next = r_phase;
            w_load       = 1'b0;
            w_hdr_load   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= PhHeader;
            r_hdr_cnt    <= '0;
            r_len        <= '0;
            r_word_count <= '0;
            r_word_idx   <= '0;
            r_base       <= '0;
            r_busy       <= 1'b0;
            r_byte_prev  <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_byte_prev <= bus.byte_recieved;
            if (w_accept) begin
                r_base     <= bus.base_addr;
                r_word_idx <= '0;
                r_hdr_cnt  <= '0;
                r_len      <= '0;
                r_busy     <= 1'b1;
            end
            if (w_hdr_load) begin
                r_len     <= {r_len[LEN_W-9:0], bus.uart_byte};
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
            end
            if (r_state == StCheck && w_state_next == StReq) begin
                r_word_count <= r_len;
            end
            if (r_state == StWrite) begin
                r_word_idx <= r_word_idx + LEN_W'(1);
            end
            if (r_state == StDone || r_state == StErr) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.read_enable = (r_state == StReq);
    assign bus.wr_en       = (r_state == StWrite);
    assign bus.frame_done  = (r_state == StDone);
    assign bus.frame_err   = (r_state == StErr);
    assign bus.busy        = r_busy;
    assign bus.word_count  = r_word_count;
    // address wraps modulo 2**ADDR_W by truncation
    assign bus.wr_addr     = r_base + r_word_idx[ADDR_W-1:0];
    assign bus.wr_data     = w_word;

endmodule

// File: tb/tb_uart_rx_frame_sequencer.sv
// Directed scoreboard bench: a byte responder feeds frames, a monitor checks writes and pulses.
module tb_uart_rx_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_sequencer_if #(.WORD_BYTES(4), .ADDR_W(10)) bus ();

    uart_rx_frame_sequencer #(
        .WORD_BYTES(4),
        .ADDR_W    (10),
        .MAX_WORDS (1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          hold_cycles = 1;

    logic [7:0]  byte_q[$];
    logic [9:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_evt_q[$];  // 2'b01 done, 2'b10 err

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [9:0] base, input int words, input int n_pay,
                              input logic [7:0] seed, input logic [7:0] step);
        logic [31:0] w;
        logic [7:0]  b;
        byte_q.push_back(8'(words >> 8));
        byte_q.push_back(8'(words));
        w = '0;
        for (int i = 0; i < n_pay; i++) begin
            b = seed + 8'(i) * step;
            byte_q.push_back(b);
            w = {w[23:0], b};
            if (i % 4 == 3) begin
                exp_addr_q.push_back(base + 10'(i / 4));
                exp_data_q.push_back(w);
            end
        end
    endtask

    task automatic start_frame(input logic [9:0] base);
        tick();
        bus.base_addr = base;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while ((exp_evt_q.size() != 0 || exp_addr_q.size() != 0 || bus.busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check({tag, "_timeout"}, 32'(cyc >= 3000), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic wait_consumed(input string tag);
        int cyc = 0;
        while (byte_q.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_consume_timeout"}, 32'(cyc >= 3000), 0);
        repeat (8) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.read_enable), 0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.frame_done), 0);
        check({tag, "_err"}, 32'(bus.frame_err), 0);
        check({tag, "_word_count"}, 32'(bus.word_count), 0);
    endtask

    // UART byte interface model: answers each read_enable with the next queued byte
    initial begin
        bus.byte_recieved = 1'b0;
        bus.uart_byte     = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.read_enable && byte_q.size() != 0) begin
                tick();
                bus.uart_byte     = byte_q.pop_front();
                bus.byte_recieved = 1'b1;
                repeat (hold_cycles) @(posedge clk);
                #1;
                bus.byte_recieved = 1'b0;
                bus.uart_byte     = 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                check("wr_expected", 32'(exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) begin
                    check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr_q.pop_front()));
                    check("wr_data", bus.wr_data, exp_data_q.pop_front());
                end
            end
            if (bus.frame_done || bus.frame_err) begin
                check("evt_expected", 32'(exp_evt_q.size() != 0), 1);
                if (exp_evt_q.size() != 0) begin
                    check("evt_kind", 32'({bus.frame_err, bus.frame_done}),
                          32'(exp_evt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Two-word frame, single-cycle byte strobes
        push_frame(10'h010, 2, 8, 8'h11, 8'h11);
        exp_evt_q.push_back(2'b01);
        start_frame(10'h010);
        drain("frame1");
        check("frame1_word_count", 32'(bus.word_count), 2);

        // Same frame with byte_recieved held for two cycles
        hold_cycles = 2;
        push_frame(10'h010, 2, 8, 8'h11, 8'h11);
        exp_evt_q.push_back(2'b01);
        start_frame(10'h010);
        drain("hold2");
        hold_cycles = 1;

        // Illegal lengths: zero and MAX_WORDS+1
        push_frame(10'h000, 0, 0, 8'h00, 8'h00);
        exp_evt_q.push_back(2'b10);
        start_frame(10'h000);
        drain("len0");
        push_frame(10'h000, 1025, 0, 8'h00, 8'h00);
        exp_evt_q.push_back(2'b10);
        start_frame(10'h000);
        drain("len1025");
        check("len_err_word_count", 32'(bus.word_count), 2);

        // Abort after 6 payload bytes of a 2-word frame
        push_frame(10'h020, 2, 6, 8'hA0, 8'h01);
        start_frame(10'h020);
        wait_consumed("abort");
        check("abort_busy_before", 32'(bus.busy), 1);
        exp_evt_q.push_back(2'b10);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        drain("abort");
        check("abort_rd_en_idle", 32'(bus.read_enable), 0);

        // Address wrap, with a start pulse while busy
        push_frame(10'h3FF, 2, 8, 8'h31, 8'h07);
        exp_evt_q.push_back(2'b01);
        start_frame(10'h3FF);
        repeat (3) tick();
        check("restart_busy", 32'(bus.busy), 1);
        start_frame(10'h100);
        drain("wrap");

        // Abort in IDLE is ignored
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (3) tick();
        check("idle_abort_busy", 32'(bus.busy), 0);

        // Start and abort together in IDLE: start wins
        push_frame(10'h0AA, 1, 4, 8'h5A, 8'h11);
        exp_evt_q.push_back(2'b01);
        tick();
        bus.base_addr = 10'h0AA;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        drain("start_abort");
        check("start_abort_word_count", 32'(bus.word_count), 1);

        // Reset in the middle of a payload, then a clean frame
        push_frame(10'h040, 2, 3, 8'h90, 8'h01);
        start_frame(10'h040);
        wait_consumed("midrst");
        check("midrst_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        push_frame(10'h050, 3, 12, 8'hC0, 8'h03);
        exp_evt_q.push_back(2'b01);
        start_frame(10'h050);
        drain("post_rst");
        check("post_rst_word_count", 32'(bus.word_count), 3);

        check("scoreboard_empty", 32'(exp_addr_q.size() + exp_evt_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
